input_port_buffer: RTL

- Per-port input stage of the router, one instance per port (L, N, E, W, S), sitting directly upstream of the arbiter.
- Stores incoming flits in a first-word-fall-through (FWFT) FIFO and drives that port's req, flit_id and length inputs to the arbiter.
- Streams a packet's flits out while this port holds the grant.
- Tracks packet framing (header, body, tail) so req stays asserted for the whole packet.

---
 rtl/input_port_buffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/input_port_buffer.sv
// input_port_buffer: per-port router input stage.
// Buffers incoming flits in a first-word-fall-through FIFO and presents the
// head flit to the arbiter. A small FSM tracks packet framing so that req
// stays asserted from the header until the tail has been streamed out.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   in_data/in_valid  incoming flit; in_ready = FIFO not full
//   grant             this port's grant from the arbiter
//   req               request to the arbiter (HEAD/XFER states)
//   flit_id           id of FIFO head flit, 0 when empty
//   length            header length, latched on IDLE->HEAD, held for packet
//   out_data          FIFO head (fall-through), out_valid = transfer strobe
//   count             FIFO occupancy
//   drop_cnt          saturating count of discarded malformed flits
module input_port_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              grant,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [11:0]       length,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [ADDR_W:0]   count,
  output logic [7:0]        drop_cnt
);

  localparam logic [2:0] ID_HDR  = 3'b001;
  localparam logic [2:0] ID_TAIL = 3'b100;

  typedef enum logic [1:0] {IDLE, HEAD, XFER} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic [ADDR_W:0]   r_count;
  logic [11:0]       r_len;
  logic [7:0]        r_drop;
  state_t            r_state, w_state_nxt;

  logic              w_empty, w_full, w_push, w_pop;
  logic              w_drop, w_out_valid, w_req, w_load_len;
  logic [DATA_W-1:0] w_head;
  logic [2:0]        w_head_id;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_head    = r_mem[r_rptr];
  assign w_head_id = w_head[DATA_W-1 -: 3];

  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign w_push = in_valid & ~w_full;
  assign w_pop  = w_out_valid | w_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_out_valid = 1'b0;
    w_drop      = 1'b0;
    w_load_len  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          if (w_head_id == ID_HDR) begin
            w_state_nxt = HEAD;
            w_load_len  = 1'b1;
          end else begin
            w_drop = 1'b1;  // stray flit with no header in front of it
          end
        end
      end
      HEAD: begin
        w_req = 1'b1;
        // Header stays at the head until granted, so empty cannot occur
        // here; the guard just keeps the pop well-defined.
        if (grant && !w_empty) begin
          w_out_valid = 1'b1;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        w_req = 1'b1;
        if (grant && !w_empty) begin
          if (w_head_id == ID_HDR) begin
            // Header without a preceding tail: discard, keep streaming.
            w_drop = 1'b1;
          end else begin
            w_out_valid = 1'b1;
            if (w_head_id == ID_TAIL) w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_len   <= '0;
      r_drop  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + ADDR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_load_len) r_len <= w_head[11:0];
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  assign in_ready  = ~w_full;
  assign req       = w_req;
  assign out_valid = w_out_valid;
  assign out_data  = w_head;
  assign flit_id   = w_empty ? 3'b000 : w_head_id;
  assign length    = r_len;
  assign count     = r_count;
  assign drop_cnt  = r_drop;

endmodule
